// File: rtl/credit_issue.sv
// Credit-gated descriptor issue: buffers request indices in a FIFO and forwards
// them downstream only while the credit pool is non-empty.
module credit_issue #(
  parameter int CREDITS = 4,
  parameter int DEPTH   = 8
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  input  logic       credit_ret,
  output logic [3:0] credit_cnt,
  output logic [6:0] fifo_cnt,
  output logic       credit_err
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_C   = 7'(DEPTH);
  localparam logic [3:0] CREDITS_C = 4'(CREDITS);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              run;
  logic              push;
  logic              pop;

  // run holds in_tready low from reset assertion until the first edge after release
  assign in_tready  = run && (fifo_cnt < DEPTH_C);
  assign out_tvalid = (fifo_cnt != '0) && (credit_cnt != '0);
  assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_tdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 7'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 7'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A return into an already-full pool is dropped and latched as an error
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      credit_cnt <= CREDITS_C;
      credit_err <= 1'b0;
    end else if (pop && !credit_ret) begin
      credit_cnt <= credit_cnt - 4'd1;
    end else if (!pop && credit_ret) begin
      if (credit_cnt == CREDITS_C) credit_err <= 1'b1;
      else                         credit_cnt <= credit_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_credit_issue.sv
// Directed and randomized self-checking bench for credit_issue (CREDITS=4, DEPTH=8).
module tb_credit_issue;

  logic       aclk;
  logic       areset;
  logic [7:0] in_tdata;
  logic       in_tvalid;
  logic       in_tready;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready;
  logic       credit_ret;
  logic [3:0] credit_cnt;
  logic [6:0] fifo_cnt;
  logic       credit_err;

  int errors = 0;
  int checks = 0;

  credit_issue #(.CREDITS(4), .DEPTH(8)) dut (
    .aclk(aclk), .areset(areset),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt), .fifo_cnt(fifo_cnt),
    .credit_err(credit_err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q[$];
  int         due[$];
  int         outstanding, sent, recv, gap, cyc;
  logic       exp_ready, exp_valid, in_x, out_x;
  logic [7:0] drain_vals [3];

  initial begin
    areset = 1'b1; in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b0; credit_ret = 1'b0;
    step();
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("rst_in_tready", in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_out_tdata", out_tdata, 8'h00);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_credit_cnt", credit_cnt, 4);
    check("rst_credit_err", credit_err, 0);
    areset = 1'b0;
    step();
    check("post_rst_in_tready", in_tready, 1);

    // Back-to-back push with open sink: one issue per cycle until credits run out
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_tdata = 8'(i); in_tvalid = 1'b1;
      step();
      check("b2b_valid", out_tvalid, 1);
      check("b2b_data", out_tdata, i);
      check("b2b_credit", credit_cnt, 4 - i);
    end
    in_tvalid = 1'b0;
    step();
    check("b2b_credit_end", credit_cnt, 0);
    check("b2b_fifo_end", fifo_cnt, 0);
    check("b2b_valid_end", out_tvalid, 0);
    step();
    check("b2b_valid_idle", out_tvalid, 0);

    // Queued index waits for a returned credit
    in_tdata = 8'h04; in_tvalid = 1'b1;
    step();
    in_tvalid = 1'b0;
    check("stall_fifo", fifo_cnt, 1);
    check("stall_valid", out_tvalid, 0);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("ret_credit", credit_cnt, 1);
    check("ret_valid", out_tvalid, 1);
    check("ret_data", out_tdata, 8'h04);
    step();
    check("ret_credit_used", credit_cnt, 0);
    check("ret_fifo_empty", fifo_cnt, 0);
    out_tready = 1'b0; credit_ret = 1'b1;
    repeat (4) step();
    credit_ret = 1'b0;
    check("refill_credit", credit_cnt, 4);
    check("refill_err", credit_err, 0);

    // Fill FIFO with sink blocked, attempt overflow push, then drain
    for (int i = 0; i < 8; i++) begin
      in_tdata = 8'(8'h10 + i); in_tvalid = 1'b1;
      step();
    end
    check("full_fifo", fifo_cnt, 8);
    check("full_in_tready", in_tready, 0);
    check("full_out_tdata", out_tdata, 8'h10);
    check("full_out_tvalid", out_tvalid, 1);
    in_tdata = 8'h18;
    step();
    in_tvalid = 1'b0;
    check("ovf_fifo", fifo_cnt, 8);
    check("ovf_out_tdata", out_tdata, 8'h10);
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", out_tdata, 8'h10 + i);
      check("drain_valid", out_tvalid, 1);
      step();
    end
    check("drain_credit", credit_cnt, 0);
    check("drain_fifo", fifo_cnt, 4);
    check("drain_valid_end", out_tvalid, 0);

    // Simultaneous pop+return and push+pop
    out_tready = 1'b0; credit_ret = 1'b1;
    step(); step();
    credit_ret = 1'b0;
    check("two_credit", credit_cnt, 2);
    check("two_credit_data", out_tdata, 8'h14);
    out_tready = 1'b1; credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("popret_credit", credit_cnt, 2);
    check("popret_fifo", fifo_cnt, 3);
    check("popret_data", out_tdata, 8'h15);
    in_tdata = 8'h20; in_tvalid = 1'b1;
    step();
    in_tvalid = 1'b0;
    check("pushpop_fifo", fifo_cnt, 3);
    check("pushpop_credit", credit_cnt, 1);
    drain_vals[0] = 8'h16; drain_vals[1] = 8'h17; drain_vals[2] = 8'h20;
    credit_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("order_data", out_tdata, drain_vals[i]);
      step();
    end
    check("order_fifo", fifo_cnt, 0);
    check("order_credit", credit_cnt, 1);
    out_tready = 1'b0;
    repeat (3) step();
    credit_ret = 1'b0;
    check("pool_full", credit_cnt, 4);
    check("pool_err_clear", credit_err, 0);

    // Return into a full pool
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    check("over_credit", credit_cnt, 4);
    check("over_err", credit_err, 1);
    repeat (3) step();
    check("over_err_sticky", credit_err, 1);

    // Reset mid-traffic discards queue and restores credits
    for (int i = 0; i < 3; i++) begin
      in_tdata = 8'(8'h30 + i); in_tvalid = 1'b1;
      step();
    end
    in_tvalid = 1'b0; out_tready = 1'b1;
    step();
    check("mid_credit", credit_cnt, 3);
    check("mid_fifo", fifo_cnt, 2);
    areset = 1'b1;
    #1;
    check("arst_fifo", fifo_cnt, 0);
    check("arst_credit", credit_cnt, 4);
    check("arst_err", credit_err, 0);
    check("arst_in_tready", in_tready, 0);
    check("arst_out_tvalid", out_tvalid, 0);
    check("arst_out_tdata", out_tdata, 8'h00);
    credit_ret = 1'b1;
    step(); step();
    credit_ret = 1'b0;
    check("arst_ret_ignored", credit_cnt, 4);
    areset = 1'b0; out_tready = 1'b0;
    step();
    check("rel_in_tready", in_tready, 1);
    check("rel_fifo", fifo_cnt, 0);
    check("rel_credit", credit_cnt, 4);

    // Randomized traffic against a reference queue
    outstanding = 0; sent = 0; recv = 0; gap = 0; cyc = 0;
    while ((recv < 500 || outstanding > 0) && cyc < 20000) begin
      exp_ready = (q.size() < 8);
      exp_valid = (q.size() > 0) && (outstanding < 4);
      check("rnd_invariant", 32'(credit_cnt) + 32'(outstanding), 4);
      check("rnd_in_tready", in_tready, exp_ready);
      check("rnd_out_tvalid", out_tvalid, exp_valid);
      if (!in_tvalid) begin
        if (gap > 0) gap--;
        else if (sent < 500) begin
          in_tdata = 8'($urandom_range(0, 31));
          in_tvalid = 1'b1;
        end
      end
      out_tready = 1'($urandom_range(0, 1));
      credit_ret = 1'b0;
      for (int i = 0; i < due.size(); i++) begin
        if (!credit_ret && due[i] <= cyc) begin
          credit_ret = 1'b1;
          due.delete(i);
        end
      end
      in_x  = in_tvalid && exp_ready;
      out_x = exp_valid && out_tready;
      if (out_x) check("rnd_out_tdata", out_tdata, q[0]);
      step();
      cyc++;
      if (out_x) begin
        void'(q.pop_front());
        recv++;
        outstanding++;
        due.push_back(cyc + int'($urandom_range(1, 20)));
      end
      if (credit_ret) outstanding--;
      if (in_x) begin
        q.push_back(in_tdata);
        sent++;
        in_tvalid = 1'b0;
        gap = int'($urandom_range(0, 3));
      end
    end
    in_tvalid = 1'b0; credit_ret = 1'b0; out_tready = 1'b0;
    check("rnd_received", recv, 500);
    check("rnd_outstanding", outstanding, 0);
    step();
    check("rnd_final_credit", credit_cnt, 4);
    check("rnd_final_err", credit_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
